// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg
// Shared types and default timing for the lock controller slice.
//   lock_state_t : controller states
//   CLK_HZ       : nominal system clock (12 MHz HSOSC-derived)
//   DEF_*        : default parameter values for lock_controller
//   cnt_width()  : counter width able to hold 0..n-1 (never below 1 bit)
//   max3()       : largest of three integers
// ---------------------------------------------------------------------------
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNLOCKED,
    FAIL,
    LOCKOUT,
    CLEAR
  } lock_state_t;

  localparam int CLK_HZ             = 12000000;
  localparam int DEF_MAX_ATTEMPTS   = 3;
  localparam int DEF_UNLOCK_CYCLES  = 24000000;
  localparam int DEF_FAIL_CYCLES    = 6000000;
  localparam int DEF_LOCKOUT_CYCLES = 120000000;
  localparam int DEF_BLINK_CYCLES   = 3000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// ---------------------------------------------------------------------------
// lock_timer
// Saturating up-counter with synchronous clear and a terminal-count flag.
//   i_clk     : system clock
//   i_rst     : asynchronous active-high reset (count -> 0)
//   i_clr     : synchronous clear (count -> 0 on next edge)
//   i_limit   : terminal count to compare against
//   o_expired : count == i_limit
// The count holds at all-ones instead of wrapping.
// ---------------------------------------------------------------------------
module lock_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != {W{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/lock_controller.sv
// ---------------------------------------------------------------------------
// lock_controller
// Consumes the entry FSM's verdict levels, drives the solenoid and status
// outputs, counts consecutive failures and enforces a timed lockout. The
// entry stage is cleared through a level req/ack: o_done is the request,
// both verdicts low is the ack.
//
// Ports:
//   i_clk            : system clock
//   i_reset          : asynchronous active-high reset
//   i_crct_pwd       : correct-code verdict (level)
//   i_incrct_pwd     : wrong-code verdict (level)
//   o_done           : clear request to entry stage (level)
//   o_unlock         : solenoid drive
//   o_fail_led       : wrong-code indicator
//   o_lockout        : lockout active
//   o_attempts_left  : MAX_ATTEMPTS - consecutive failures
//   o_alarm          : blinking alarm during lockout
//
// Optional feature macro: LOCK_ALARM_EN (blinking alarm in LOCKOUT; when
// undefined o_alarm is tied low and BLINK_CYCLES does not exist).
//
// state    | meaning
// IDLE     | waiting for a verdict
// UNLOCKED | solenoid driven for UNLOCK_CYCLES
// FAIL     | fail_led shown for FAIL_CYCLES
// LOCKOUT  | verdicts ignored for LOCKOUT_CYCLES
// CLEAR    | done held until both verdicts are low
// ---------------------------------------------------------------------------
module lock_controller
  import lock_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int FAIL_CYCLES    = DEF_FAIL_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
`ifdef LOCK_ALARM_EN
  ,
  parameter int BLINK_CYCLES   = DEF_BLINK_CYCLES
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_crct_pwd,
  input  logic       i_incrct_pwd,
  output logic       o_done,
  output logic       o_unlock,
  output logic       o_fail_led,
  output logic       o_lockout,
  output logic [3:0] o_attempts_left,
  output logic       o_alarm
);

  localparam int TW = cnt_width(max3(UNLOCK_CYCLES, FAIL_CYCLES, LOCKOUT_CYCLES));
  localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

  lock_state_t r_state;
  logic        r_done;
  logic        r_unlock;
  logic        r_fail_led;
  logic        r_lockout;
  logic [3:0]  r_fail_cnt;

  logic [TW-1:0] w_tmr_limit;
  logic          w_tmr_clr;
  logic          w_tmr_exp;
  logic [3:0]    w_fail_inc;

  always_comb begin
    w_tmr_limit = '0;
    case (r_state)
      UNLOCKED: w_tmr_limit = TW'(UNLOCK_CYCLES - 1);
      FAIL:     w_tmr_limit = TW'(FAIL_CYCLES - 1);
      LOCKOUT:  w_tmr_limit = TW'(LOCKOUT_CYCLES - 1);
      default:  w_tmr_limit = '0;
    endcase
  end

  // Timer is held at zero in the untimed states and cleared on expiry, so
  // every timed state starts counting from 0 on its first cycle.
  assign w_tmr_clr = (r_state == IDLE) || (r_state == CLEAR) || w_tmr_exp;

  lock_timer #(.W(TW)) u_state_timer (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_clr     (w_tmr_clr),
    .i_limit   (w_tmr_limit),
    .o_expired (w_tmr_exp)
  );

  assign w_fail_inc = (r_fail_cnt >= MAX_A) ? MAX_A : (r_fail_cnt + 4'd1);

`ifdef LOCK_ALARM_EN
  localparam int BW = cnt_width(BLINK_CYCLES);

  logic r_alarm;
  logic w_blink_clr;
  logic w_blink_exp;

  assign w_blink_clr = (r_state != LOCKOUT) || w_blink_exp;

  lock_timer #(.W(BW)) u_blink_timer (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_clr     (w_blink_clr),
    .i_limit   (BW'(BLINK_CYCLES - 1)),
    .o_expired (w_blink_exp)
  );

  assign o_alarm = r_alarm;
`else
  assign o_alarm = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_unlock   <= 1'b0;
      r_fail_led <= 1'b0;
      r_lockout  <= 1'b0;
      r_fail_cnt <= 4'd0;
`ifdef LOCK_ALARM_EN
      r_alarm    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_crct_pwd && !i_incrct_pwd) begin
            r_state    <= UNLOCKED;
            r_unlock   <= 1'b1;
            r_done     <= 1'b1;
            r_fail_cnt <= 4'd0;
          end else if (i_incrct_pwd) begin
            // Both verdicts high lands here as well: fail safe.
            r_fail_cnt <= w_fail_inc;
            r_done     <= 1'b1;
            if (w_fail_inc == MAX_A) begin
              r_state   <= LOCKOUT;
              r_lockout <= 1'b1;
`ifdef LOCK_ALARM_EN
              r_alarm   <= 1'b1;
`endif
            end else begin
              r_state    <= FAIL;
              r_fail_led <= 1'b1;
            end
          end
        end
        UNLOCKED: begin
          if (w_tmr_exp) begin
            r_state  <= CLEAR;
            r_unlock <= 1'b0;
          end
        end
        FAIL: begin
          if (w_tmr_exp) begin
            r_state    <= CLEAR;
            r_fail_led <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (w_tmr_exp) begin
            r_state    <= CLEAR;
            r_lockout  <= 1'b0;
            r_fail_cnt <= 4'd0;
`ifdef LOCK_ALARM_EN
            r_alarm    <= 1'b0;
          end else if (w_blink_exp) begin
            r_alarm    <= ~r_alarm;
`endif
          end
        end
        CLEAR: begin
          if (!i_crct_pwd && !i_incrct_pwd) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_done          = r_done;
  assign o_unlock        = r_unlock;
  assign o_fail_led      = r_fail_led;
  assign o_lockout       = r_lockout;
  assign o_attempts_left = MAX_A - r_fail_cnt;

endmodule

// File: tb/tb_lock_controller.sv
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       crct = 1'b0;
  logic       incrct = 1'b0;
  logic       done;
  logic       unlock;
  logic       fail_led;
  logic       lockout;
  logic [3:0] attempts;
  logic       alarm;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lock_controller #(
    .MAX_ATTEMPTS   (3),
    .UNLOCK_CYCLES  (8),
    .FAIL_CYCLES    (4),
    .LOCKOUT_CYCLES (16)
`ifdef LOCK_ALARM_EN
    ,
    .BLINK_CYCLES   (2)
`endif
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_crct_pwd      (crct),
    .i_incrct_pwd    (incrct),
    .o_done          (done),
    .o_unlock        (unlock),
    .o_fail_led      (fail_led),
    .o_lockout       (lockout),
    .o_attempts_left (attempts),
    .o_alarm         (alarm)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One wrong code, acked on the first cycle the request is seen.
  task automatic do_fail(input logic [3:0] exp_left);
    int fl;
    fl = 0;
    incrct = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (fail_led) fl++;
      if (i == 0) begin
        chk1("fail_led_on", fail_led, 1'b1);
        chk1("fail_done_on", done, 1'b1);
        chk4("fail_attempts", attempts, exp_left);
        chk1("fail_unlock", unlock, 1'b0);
        chk1("fail_alarm", alarm, 1'b0);
        incrct = 1'b0;
      end
    end
    chki("fail_led_cycles", fl, 4);
    chk1("fail_done_off", done, 1'b0);
    chk4("fail_attempts_after", attempts, exp_left);
  endtask

  initial begin
    int ucnt;
    int dcnt;
    int lcnt;

    // Reset values
    step(2);
    chk1("rst_done", done, 1'b0);
    chk1("rst_unlock", unlock, 1'b0);
    chk1("rst_fail_led", fail_led, 1'b0);
    chk1("rst_lockout", lockout, 1'b0);
    chk1("rst_alarm", alarm, 1'b0);
    chk4("rst_attempts", attempts, 4'd3);
    rst = 1'b0;
    step(2);
    chk1("idle_done", done, 1'b0);

    // Correct code, ack 3 cycles after done rises
    ucnt = 0;
    dcnt = 0;
    crct = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (unlock) ucnt++;
      if (done) dcnt++;
      if (i == 0) begin
        chk1("ok_unlock_on", unlock, 1'b1);
        chk1("ok_done_on", done, 1'b1);
      end
      if (i == 3) crct = 1'b0;
    end
    chki("ok_unlock_cycles", ucnt, 8);
    chki("ok_done_cycles", dcnt, 9);
    chk1("ok_done_off", done, 1'b0);
    chk4("ok_attempts", attempts, 4'd3);

    // Three wrong codes -> lockout
    do_fail(4'd2);
    do_fail(4'd1);
    incrct = 1'b1;
    step(1);
    chk1("lk_lockout_on", lockout, 1'b1);
    chk1("lk_done_on", done, 1'b1);
    chk1("lk_fail_led", fail_led, 1'b0);
    chk4("lk_attempts", attempts, 4'd0);
    incrct = 1'b0;
    crct = 1'b1;
    lcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (lockout) lcnt++;
      chk1("lk_unlock_ignored", unlock, 1'b0);
`ifdef LOCK_ALARM_EN
      chk1("lk_alarm_pattern", alarm, ((i / 2) % 2) == 0);
`else
      chk1("lk_alarm_off", alarm, 1'b0);
`endif
      step(1);
    end
    chki("lk_lockout_cycles", lcnt, 16);
    chk1("lk_lockout_off", lockout, 1'b0);
    chk1("lk_done_held", done, 1'b1);
    chk1("lk_alarm_exit", alarm, 1'b0);
    chk4("lk_attempts_after", attempts, 4'd3);
    crct = 1'b0;
    step(1);
    chk1("lk_done_off", done, 1'b0);
    step(1);
    chk1("lk_no_unlock", unlock, 1'b0);

    // Two wrong codes, then a correct code
    do_fail(4'd2);
    do_fail(4'd1);
    crct = 1'b1;
    step(1);
    chk1("mix_unlock_on", unlock, 1'b1);
    chk4("mix_attempts_reset", attempts, 4'd3);
    crct = 1'b0;
    step(12);
    chk1("mix_done_off", done, 1'b0);
    chk4("mix_attempts_after", attempts, 4'd3);

    // Both verdicts high together
    crct = 1'b1;
    incrct = 1'b1;
    step(1);
    chk1("both_fail_led", fail_led, 1'b1);
    chk1("both_unlock", unlock, 1'b0);
    chk4("both_attempts", attempts, 4'd2);
    chk1("both_done", done, 1'b1);
    crct = 1'b0;
    incrct = 1'b0;
    step(7);
    chk1("both_done_off", done, 1'b0);

    // Ack withheld for 50 cycles
    ucnt = 0;
    crct = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (unlock) ucnt++;
      if (i == 0) chk4("hold_attempts", attempts, 4'd3);
    end
    chki("hold_unlock_cycles", ucnt, 8);
    chk1("hold_done_held", done, 1'b1);
    chk1("hold_unlock_off", unlock, 1'b0);
    crct = 1'b0;
    step(1);
    chk1("hold_done_off", done, 1'b0);
    step(1);
    chk1("hold_no_unlock", unlock, 1'b0);

    // Reset mid-UNLOCKED (cycle 4)
    crct = 1'b1;
    step(1);
    chk1("rsu_unlock_on", unlock, 1'b1);
    step(3);
    chk1("rsu_unlock_c4", unlock, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rsu_unlock_async", unlock, 1'b0);
    chk1("rsu_done_async", done, 1'b0);
    crct = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);

    // Reset mid-LOCKOUT
    do_fail(4'd2);
    do_fail(4'd1);
    incrct = 1'b1;
    step(1);
    chk1("rsl_lockout_on", lockout, 1'b1);
    incrct = 1'b0;
    step(4);
    chk1("rsl_lockout_mid", lockout, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rsl_lockout_async", lockout, 1'b0);
    chk1("rsl_done_async", done, 1'b0);
    chk1("rsl_alarm_async", alarm, 1'b0);
    chk4("rsl_attempts_async", attempts, 4'd3);
    step(1);
    rst = 1'b0;
    step(2);
    chk1("rsl_lockout_after", lockout, 1'b0);
    chk1("rsl_done_after", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Downstream of the keypad/password-entry FSM. Consumes its registered verdict levels (crct_pwd / incrct_pwd) and drives the lock actuator.
- Counts failed attempts, enforces a timed lockout, and requests clearing of the entry stage through done, using a level req/ack handshake.
- Sits in the top level between the entry FSM and the board pins (solenoid driver, status LEDs).

Parameters:
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout; legal range 1..15.
- UNLOCK_CYCLES, 24000000: cycles unlock is held high (2 s at 12 MHz).
- FAIL_CYCLES, 6000000: cycles fail_led is shown after a wrong code.
- LOCKOUT_CYCLES, 120000000: lockout duration in cycles.
- BLINK_CYCLES, 3000000: half-period of the alarm blink (used only with the optional feature).

Ports:
- clk  in  1  system clock (HSOSC-derived)
- reset  in  1  asynchronous, active-high reset
- crct_pwd  in  1  entry stage reports a correct 4-digit code; level, held until the entry stage is cleared
- incrct_pwd  in  1  entry stage reports a wrong 4-digit code; level, held until cleared
- done  out  1  clear request to the entry stage; level
- unlock  out  1  solenoid drive
- fail_led  out  1  wrong-code indicator
- lockout  out  1  lockout active
- attempts_left  out  4  MAX_ATTEMPTS minus current consecutive failures
- alarm  out  1  blinking alarm during lockout

Behaviour:
- Reset (async, active-high) state and outputs:
  - state=IDLE, all timers=0, fail_cnt=0.
  - done=0, unlock=0, fail_led=0, lockout=0, alarm=0.
  - attempts_left=MAX_ATTEMPTS.
- All outputs are registered and change only on the posedge clk after a state or counter update.
- States: IDLE, UNLOCKED, FAIL, LOCKOUT, CLEAR.
- IDLE:
  - Samples verdicts every cycle. If crct_pwd && !incrct_pwd, go to UNLOCKED and set fail_cnt=0.
  - Else if incrct_pwd (this includes both inputs high, which is treated as a failure for fail-safe operation): increment fail_cnt.
  - After the increment, if fail_cnt==MAX_ATTEMPTS go to LOCKOUT, else go to FAIL.
  - With both inputs low, stay in IDLE.
- UNLOCKED:
  - unlock=1 and done=1 from the first cycle in this state.
  - Timer counts from 0. At timer==UNLOCK_CYCLES-1, go to CLEAR and drop unlock.
  - unlock is therefore high for exactly UNLOCK_CYCLES cycles.
- FAIL:
  - fail_led=1 and done=1. Stays FAIL_CYCLES cycles, then goes to CLEAR.
- LOCKOUT:
  - lockout=1 and done=1. Stays LOCKOUT_CYCLES cycles.
  - On exit: fail_cnt=0, go to CLEAR.
  - Verdict inputs are ignored for the whole period.
- CLEAR:
  - done stays 1 until crct_pwd==0 and incrct_pwd==0 are both sampled (the ack).
  - On the ack, done=0 on the next edge and the block returns to IDLE.
  - There is no timeout; CLEAR waits indefinitely for the ack.
- done handshake rules:
  - done rises only on entry to UNLOCKED, FAIL or LOCKOUT.
  - done falls only on leaving CLEAR.
  - A verdict still high after return to IDLE cannot be seen twice, because IDLE is entered only after the ack.
- attempts_left = MAX_ATTEMPTS - fail_cnt, combinationally derived from the fail_cnt register.
- Timers:
  - One shared timer, width $clog2 of the largest *_CYCLES value.
  - Cleared on every state change; saturates and never wraps.
- fail_cnt width is 4 bits. It saturates at MAX_ATTEMPTS.
- Reset during UNLOCKED drops unlock asynchronously; reset during LOCKOUT ends the lockout. This is intended behaviour.

Optional Feature:
- Macro LOCK_ALARM_EN.
- Defined:
  - In LOCKOUT, alarm toggles every BLINK_CYCLES cycles. It starts at 1 on LOCKOUT entry.
  - It is forced to 0 on exit from LOCKOUT.
  - The blink counter is separate from the state timer.
- Undefined:
  - alarm is tied to 0.
  - The blink counter is not instantiated, and BLINK_CYCLES is unused.

Decomposition:
- Shared package lock_pkg holds:
  - typedef enum logic [2:0] lock_state_t {IDLE, UNLOCKED, FAIL, LOCKOUT, CLEAR};
  - default timing constants (CLK_HZ=12000000 and the *_CYCLES defaults).
- One sub-module, lock_timer: a parameterised saturating up-counter with clear and expired outputs.
  - Instantiated once for the state timer.
  - Instantiated a second time for the blink counter under LOCK_ALARM_EN.

Test Plan:
- All tests use UNLOCK_CYCLES=8, FAIL_CYCLES=4, LOCKOUT_CYCLES=16 and MAX_ATTEMPTS=3.
- Correct code: pulse crct_pwd high, then drop it 3 cycles after done rises.
  - Required: unlock high for exactly 8 cycles; done high from the UNLOCKED entry until 1 cycle after the ack; return to IDLE; attempts_left=3.
- Three wrong codes: each incrct_pwd is acked promptly.
  - Required: attempts_left steps 2, then 1, then 0.
  - Required: the third failure enters LOCKOUT with lockout=1 for 16 cycles; crct_pwd asserted during lockout is ignored (unlock stays 0).
  - Required: after lockout, attempts_left=3.
- Two wrong codes, then a correct code.
  - Required: fail_cnt resets to 0 and attempts_left=3 after the unlock.
- Both verdicts high in the same cycle.
  - Required: treated as a failure (fail_led=1, attempts_left=2, unlock=0).
- Ack withheld: keep crct_pwd high for 50 cycles.
  - Required: after unlock ends the block stays in CLEAR with done=1 and no second unlock; it returns to IDLE 1 cycle after crct_pwd falls.
- Reset asserted mid-UNLOCKED (cycle 4) and mid-LOCKOUT.
  - Required: outputs go to reset values immediately (before the next clk edge).
  - With LOCK_ALARM_EN and BLINK_CYCLES=2: alarm pattern 1,1,0,0,... during lockout; alarm stays 0 outside lockout.
